// File: rtl/srcnn_mul_pipe.sv
// srcnn_mul_pipe: pipelined, saturating fixed-point multiplier for the SRCNN datapath.
// Operands are extended by one bit (sign or zero per DINx_SIGNED) and multiplied
// exactly. The product is arithmetically shifted right by OUT_SHIFT and clamped to
// dout_WIDTH (signed domain if either operand is signed, else unsigned).
// Optional build macro SRCNN_MUL_ROUND_EN: round half-up before the shift.
// Without it the shift truncates toward -inf.
// Ports:
//   ap_clk, ap_rst     clock, synchronous active-high reset
//   ce                 clock enable; 0 freezes all state
//   in_valid/in_ready  input handshake; din0/din1 operands
//   out_valid/out_ready output handshake; dout result, sat = dout was clamped
// The result leaves the pipeline NUM_STAGE advancing edges after the handshake edge.
`timescale 1ns/1ps
module srcnn_mul_pipe #(
    parameter int ID          = 1,
    parameter int NUM_STAGE   = 3,
    parameter int din0_WIDTH  = 9,
    parameter int din1_WIDTH  = 9,
    parameter int dout_WIDTH  = 18,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 0,
    parameter int OUT_SHIFT   = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  sat
);

    // P: exact product width; Q: one guard bit for the optional rounding add;
    // M: wide enough to hold both the shifted value and the clamp limits.
    localparam int P = din0_WIDTH + din1_WIDTH + 2;
    localparam int Q = P + 1;
    localparam int M = ((Q > dout_WIDTH) ? Q : dout_WIDTH) + 1;
    localparam bit SGN = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

    localparam logic signed [M-1:0] ONE  = 1;
    localparam logic signed [M-1:0] SMAX = (ONE <<< (dout_WIDTH - 1)) - ONE;
    localparam logic signed [M-1:0] SMIN = ~SMAX;
    localparam logic signed [M-1:0] UMAX = (ONE <<< dout_WIDTH) - ONE;

    logic                  s0;
    logic                  s1;
    logic signed [P-1:0]   op0;
    logic signed [P-1:0]   op1;
    logic signed [P-1:0]   prod;
    logic signed [Q-1:0]   wide;
    logic signed [Q-1:0]   shifted;
    logic signed [M-1:0]   sv;
    logic [dout_WIDTH-1:0] res;
    logic                  clip;

    logic                  advance;
    logic                  acc;
    logic [NUM_STAGE-1:0]  v_q;
    logic [NUM_STAGE-1:0]  s_q;
    logic [dout_WIDTH-1:0] d_q [NUM_STAGE];

    // Operand extension straight to product width keeps the multiply exact.
    assign s0   = (DIN0_SIGNED != 0) && din0[din0_WIDTH-1];
    assign s1   = (DIN1_SIGNED != 0) && din1[din1_WIDTH-1];
    assign op0  = {{(P - din0_WIDTH){s0}}, din0};
    assign op1  = {{(P - din1_WIDTH){s1}}, din1};
    assign prod = op0 * op1;

`ifdef SRCNN_MUL_ROUND_EN
    localparam int HS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic signed [Q-1:0] ONEQ = 1;
    localparam logic signed [Q-1:0] HALF = (OUT_SHIFT > 0) ? (ONEQ <<< HS) : '0;
    assign wide = {prod[P-1], prod} + HALF;
`else
    assign wide = {prod[P-1], prod};
`endif

    assign shifted = wide >>> OUT_SHIFT;
    assign sv      = {{(M - Q){shifted[Q-1]}}, shifted};

    always_comb begin
        res  = sv[dout_WIDTH-1:0];
        clip = 1'b0;
        if (SGN) begin
            if (sv > SMAX) begin
                res  = SMAX[dout_WIDTH-1:0];
                clip = 1'b1;
            end else if (sv < SMIN) begin
                res  = SMIN[dout_WIDTH-1:0];
                clip = 1'b1;
            end
        end else begin
            if (sv[M-1]) begin
                res  = '0;
                clip = 1'b1;
            end else if (sv > UMAX) begin
                res  = UMAX[dout_WIDTH-1:0];
                clip = 1'b1;
            end
        end
    end

    // Global stall: every stage moves only when the head can move.
    assign out_valid = v_q[NUM_STAGE-1];
    assign advance   = ce & (~out_valid | out_ready);
    assign in_ready  = advance;
    assign acc       = in_valid & advance;
    assign dout      = d_q[NUM_STAGE-1];
    assign sat       = s_q[NUM_STAGE-1];

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            v_q <= '0;
            s_q <= '0;
            for (int i = 0; i < NUM_STAGE; i++) begin
                d_q[i] <= '0;
            end
        end else if (advance) begin
            // Bubbles carry zero data so an idle output reads 0.
            v_q[0] <= acc;
            s_q[0] <= acc & clip;
            d_q[0] <= acc ? res : '0;
            for (int i = 1; i < NUM_STAGE; i++) begin
                v_q[i] <= v_q[i-1];
                s_q[i] <= s_q[i-1];
                d_q[i] <= d_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_srcnn_mul_pipe.sv
// tb_srcnn_mul_pipe: directed self-checking bench for srcnn_mul_pipe.
// Several parameterisations share one stimulus bus; each task checks its own instance.
`timescale 1ns/1ps
module tb_srcnn_mul_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [8:0] a = '0;
    logic [8:0] b = '0;

    logic        rdy0, rdy1, rdy2, rdy3, rdy4;
    logic        ov0, ov1, ov2, ov3, ov4;
    logic        s0, s1, s2, s3, s4;
    logic [17:0] d0, d1, d3, d4;
    logic [7:0]  d2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    srcnn_mul_pipe u0 (
        .ap_clk(clk), .ap_rst(rst), .ce(ce),
        .in_valid(in_valid), .in_ready(rdy0), .din0(a), .din1(b),
        .out_valid(ov0), .out_ready(out_ready), .dout(d0), .sat(s0)
    );

    srcnn_mul_pipe #(.DIN0_SIGNED(1)) u1 (
        .ap_clk(clk), .ap_rst(rst), .ce(ce),
        .in_valid(in_valid), .in_ready(rdy1), .din0(a), .din1(b),
        .out_valid(ov1), .out_ready(out_ready), .dout(d1), .sat(s1)
    );

    srcnn_mul_pipe #(.dout_WIDTH(8)) u2 (
        .ap_clk(clk), .ap_rst(rst), .ce(ce),
        .in_valid(in_valid), .in_ready(rdy2), .din0(a), .din1(b),
        .out_valid(ov2), .out_ready(out_ready), .dout(d2), .sat(s2)
    );

    srcnn_mul_pipe #(.DIN0_SIGNED(1), .OUT_SHIFT(2)) u3 (
        .ap_clk(clk), .ap_rst(rst), .ce(ce),
        .in_valid(in_valid), .in_ready(rdy3), .din0(a), .din1(b),
        .out_valid(ov3), .out_ready(out_ready), .dout(d3), .sat(s3)
    );

    srcnn_mul_pipe #(.NUM_STAGE(4)) u4 (
        .ap_clk(clk), .ap_rst(rst), .ce(ce),
        .in_valid(in_valid), .in_ready(rdy4), .din0(a), .din1(b),
        .out_valid(ov4), .out_ready(out_ready), .dout(d4), .sat(s4)
    );

`ifdef SRCNN_MUL_ROUND_EN
    localparam logic [17:0] EXP_SH = 18'd4;
`else
    localparam logic [17:0] EXP_SH = 18'd3;
`endif

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // One beat through a 3-stage instance; result is visible on return.
    task automatic drive_beat(input logic [8:0] x, input logic [8:0] y);
        in_valid = 1'b1;
        a = x;
        b = y;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ce = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b0;
        cyc();
        cyc();
        #1;
        checks++;
        if (ov0 !== 1'b0 || d0 !== 18'd0 || s0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: ov=%b dout=%0d sat=%b want 0 0 0", ov0, d0, s0);
        end
        checks++;
        if (ov4 !== 1'b0 || d4 !== 18'd0) begin
            errors++;
            $display("FAIL reset_out4: ov=%b dout=%0d want 0 0", ov4, d4);
        end
        checks++;
        if (rdy0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_ce1: got %b want 1", rdy0);
        end
        ce = 1'b0;
        #1;
        checks++;
        if (rdy0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_ce0: got %b want 0", rdy0);
        end
        ce = 1'b1;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_default();
        in_valid = 1'b1;
        a = 9'd511;
        b = 9'd511;
        #1;
        checks++;
        if (rdy0 !== 1'b1) begin
            errors++;
            $display("FAIL default_ready: got %b want 1", rdy0);
        end
        cyc();
        in_valid = 1'b0;
        checks++;
        if (ov0 !== 1'b0) begin
            errors++;
            $display("FAIL default_early1: out_valid %b want 0", ov0);
        end
        cyc();
        checks++;
        if (ov0 !== 1'b0) begin
            errors++;
            $display("FAIL default_early2: out_valid %b want 0", ov0);
        end
        cyc();
        checks++;
        if (ov0 !== 1'b1 || d0 !== 18'h3FC01 || s0 !== 1'b0) begin
            errors++;
            $display("FAIL default_511sq: ov=%b dout=%h sat=%b want 1 3fc01 0", ov0, d0, s0);
        end
        cyc();
        checks++;
        if (ov0 !== 1'b0) begin
            errors++;
            $display("FAIL default_bubble: out_valid %b want 0", ov0);
        end
    endtask

    task automatic test_signed();
        drive_beat(9'h1FF, 9'd3);
        checks++;
        if (ov1 !== 1'b1 || d1 !== 18'h3FFFD || s1 !== 1'b0) begin
            errors++;
            $display("FAIL signed_m1x3: ov=%b dout=%h sat=%b want 1 3fffd 0", ov1, d1, s1);
        end
        drive_beat(9'h100, 9'd511);
        checks++;
        if (ov1 !== 1'b1 || d1 !== 18'h20100 || s1 !== 1'b0) begin
            errors++;
            $display("FAIL signed_m256x511: ov=%b dout=%h sat=%b want 1 20100 0", ov1, d1, s1);
        end
    endtask

    task automatic test_saturate();
        drive_beat(9'd20, 9'd20);
        checks++;
        if (ov2 !== 1'b1 || d2 !== 8'd255 || s2 !== 1'b1) begin
            errors++;
            $display("FAIL sat_20x20: ov=%b dout=%0d sat=%b want 1 255 1", ov2, d2, s2);
        end
        drive_beat(9'd15, 9'd17);
        checks++;
        if (ov2 !== 1'b1 || d2 !== 8'd255 || s2 !== 1'b0) begin
            errors++;
            $display("FAIL sat_15x17: ov=%b dout=%0d sat=%b want 1 255 0", ov2, d2, s2);
        end
    endtask

    task automatic test_shift();
        drive_beat(9'd3, 9'd5);
        checks++;
        if (ov3 !== 1'b1 || d3 !== EXP_SH || s3 !== 1'b0) begin
            errors++;
            $display("FAIL shift_15: ov=%b dout=%0d sat=%b want 1 %0d 0", ov3, d3, s3, EXP_SH);
        end
        drive_beat(9'h1F1, 9'd1);
        checks++;
        if (ov3 !== 1'b1 || d3 !== 18'h3FFFC || s3 !== 1'b0) begin
            errors++;
            $display("FAIL shift_m15: ov=%b dout=%h sat=%b want 1 3fffc 0", ov3, d3, s3);
        end
    endtask

    task automatic test_back_to_back();
        int got;
        got = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 22; c++) begin
            in_valid = (c < 16);
            a = 9'(c + 1);
            b = 9'(c + 1);
            #1;
            if (c < 16) begin
                checks++;
                if (rdy0 !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready c=%0d: got %b want 1", c, rdy0);
                end
            end
            cyc();
            if (ov0 === 1'b1) begin
                checks++;
                if (c + 1 != got + 3 || d0 !== 18'((got + 1) * (got + 1))) begin
                    errors++;
                    $display("FAIL b2b_result %0d: step %0d dout %0d want step %0d dout %0d",
                             got, c + 1, d0, got + 3, (got + 1) * (got + 1));
                end
                got++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got != 16) begin
            errors++;
            $display("FAIL b2b_count: got %0d results want 16", got);
        end
    endtask

    task automatic test_stall();
        int sent;
        int got;
        logic        acc;
        logic        hold;
        logic        pv;
        logic [17:0] pd;
        logic        want_rdy;
        sent = 0;
        got = 0;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 6 && c < 11);
            ce = !(c == 14 || c == 15);
            in_valid = (sent < 10);
            a = 9'(sent + 3);
            b = 9'(2 * sent + 1);
            #1;
            want_rdy = out_ready && ce;
            checks++;
            if (rdy0 !== want_rdy) begin
                errors++;
                $display("FAIL stall_ready c=%0d: got %b want %b", c, rdy0, want_rdy);
            end
            if (ov0 === 1'b1 && out_ready && ce) begin
                checks++;
                if (d0 !== 18'((got + 3) * (2 * got + 1))) begin
                    errors++;
                    $display("FAIL stall_result %0d: dout %0d want %0d",
                             got, d0, (got + 3) * (2 * got + 1));
                end
                got++;
            end
            acc = in_valid && rdy0;
            hold = !want_rdy;
            pv = ov0;
            pd = d0;
            cyc();
            if (hold) begin
                checks++;
                if (ov0 !== pv || d0 !== pd) begin
                    errors++;
                    $display("FAIL stall_hold c=%0d: ov=%b dout=%0d want %b %0d", c, ov0, d0, pv, pd);
                end
            end
            if (acc) sent++;
        end
        in_valid = 1'b0;
        ce = 1'b1;
        out_ready = 1'b1;
        checks++;
        if (got != 10 || sent != 10) begin
            errors++;
            $display("FAIL stall_count: got %0d sent %0d want 10 10", got, sent);
        end
    endtask

    task automatic test_reset_mid();
        ce = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 9'(7 + i);
            b = 9'(7 + i);
            cyc();
        end
        in_valid = 1'b0;
        checks++;
        if (ov4 !== 1'b0) begin
            errors++;
            $display("FAIL rmid_inflight: out_valid %b want 0", ov4);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (ov4 !== 1'b0 || d4 !== 18'd0 || s4 !== 1'b0) begin
            errors++;
            $display("FAIL rmid_cleared: ov=%b dout=%0d sat=%b want 0 0 0", ov4, d4, s4);
        end
        for (int i = 0; i < 6; i++) begin
            cyc();
            checks++;
            if (ov4 !== 1'b0) begin
                errors++;
                $display("FAIL rmid_ghost %0d: out_valid %b dout %0d want 0", i, ov4, d4);
            end
        end
        in_valid = 1'b1;
        a = 9'd2;
        b = 9'd3;
        cyc();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) begin
                checks++;
                if (ov4 !== 1'b0) begin
                    errors++;
                    $display("FAIL rmid_early k=%0d: out_valid %b want 0", k, ov4);
                end
                cyc();
            end else begin
                checks++;
                if (ov4 !== 1'b1 || d4 !== 18'd6 || s4 !== 1'b0) begin
                    errors++;
                    $display("FAIL rmid_next: ov=%b dout=%0d sat=%b want 1 6 0", ov4, d4, s4);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_signed();
        test_saturate();
        test_shift();
        test_back_to_back();
        test_stall();
        repeat (6) cyc();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
